seven_seg_capture: RTL and testbench
====================================

// Module: seven_seg_capture
// PURPOSE
//   Inverse of the 7-seg decode path: watches a multiplexed display bus (anodes + gfedcba
//   cathodes), waits until each {anode, segment} combination is stable, maps the pattern
//   back to a digit code and holds one nibble per display position. Used as an on-chip
//   self-check that the reels/score on the display match the game logic.
// PARAMETERS
//   NUM_DIGITS       4  number of multiplexed positions (an width), >=1
//   STABLE_CYCLES    4  consecutive identical registered samples required before capture, >=1
//   ANODE_ACTIVE_LOW 1  1: an[i]=0 selects digit i; 0: an[i]=1 selects digit i
// PORTS
//   clk          in   1             system clock, all logic on rising edge
//   rst_n        in   1             synchronous reset, active-low
//   an           in   NUM_DIGITS    anode drive under observation
//   seg          in   7             segment drive gfedcba, 0 = segment ON
//   digits       out  4*NUM_DIGITS  digits[4i+3:4i] = last captured code of position i
//   digit_valid  out  NUM_DIGITS    bit i = position i holds a legal captured code
//   frame_done   out  1             1-cycle pulse: every position captured since last pulse
//   err_pattern  out  1             1-cycle pulse: stable pattern not in decode table
//   err_anode    out  1             level: registered anode bus has >1 position selected
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): digits=all 4'hF, digit_valid=0, frame_done=0, err_pattern=0,
//     err_anode=0; sample regs, stability counter, seen-mask cleared; capture re-armed.
//   Stage 1: an/seg registered every edge into r_an/r_seg (no other use of raw inputs).
//   Anode decode of r_an (polarity per ANODE_ACTIVE_LOW): exactly one selected -> idx;
//     none selected -> idle; more than one -> err_anode<=1 next edge, else err_anode<=0.
//   Stability counter cnt: if {r_an,r_seg} differs from previous registered value, or r_an
//     not one-hot: cnt<=0, armed<=1. Else if cnt<STABLE_CYCLES-1: cnt<=cnt+1 (saturates).
//   Capture: when armed, r_an one-hot and cnt==STABLE_CYCLES-1 -> on next edge act once,
//     armed<=0; no re-capture until the combination changes (steady display = one event).
//   Latency: inputs settled before edge 0 -> outputs change after edge STABLE_CYCLES
//     (i.e. the (STABLE_CYCLES+1)-th rising edge).
//   Decode table (r_seg -> code): 1000000->0 1111001->1 0100100->2 0110000->3 0011001->4
//     0010010->5 0000010->6 1111000->7 0000000->8 0010000->9 1111111(blank)->4'hF.
//   Legal pattern: digits[idx]<=code, digit_valid[idx]<=1, seen[idx]<=1 (blank is legal).
//   Illegal pattern: err_pattern pulses 1 cycle, digits[idx] unchanged, digit_valid[idx]<=0,
//     seen[idx] unchanged.
//   Frame: when the capture makes seen all-ones, frame_done pulses in the same cycle the
//     final digit register updates and seen<=0 simultaneously; recaptures of a position
//     already in seen do not pulse. Idle/multi-hot periods never set seen.
//   Reset mid-count or mid-frame: count and partial frame discarded, no capture afterwards
//     until a fresh STABLE_CYCLES window completes.
// TESTING
//   1 rst_n=0 for 2 edges, random an/seg -> digits=16'hFFFF, digit_valid=0, all flags 0.
//   2 an=4'b1110, seg=7'b0100100 held 10 cycles (STABLE_CYCLES=4) -> digits[3:0]=2,
//     digit_valid[0]=1 after 5th edge, exactly one capture, frame_done stays 0.
//   3 same as 2 but seg changes to 7'b0110000 after 3 cycles, held 2 -> no capture.
//   4 scan positions 0..3 with 1,2,3,4 each 8 cycles -> digits=16'h4321, valid=4'hF,
//     frame_done single pulse coincident with digits[15:12] update; rescan -> second pulse.
//   5 after 4, position 1 shows 7'b1010101 for 8 cycles -> err_pattern one pulse,
//     digits[7:4]=2 retained, digit_valid=4'b1101.
//   6 an=4'b1100 held 6 cycles -> err_anode=1 from 2nd edge to 1 edge after release, no
//     capture; rst_n=0 at cnt==2 of a legal hold -> no capture for that window.

Source files
------------

// File: rtl/seven_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_capture
// Purpose  : Observes a multiplexed seven-segment display bus (anodes plus
//            active-low gfedcba cathodes), waits until each {anode, segment}
//            combination has been stable for STABLE_CYCLES registered
//            samples, decodes the segment pattern back into a digit code and
//            holds one nibble per display position. Serves as an on-chip
//            check that what is shown matches what the game logic intended.
// Ports    : clk          - system clock, rising edge
//            rst_n        - synchronous reset, active low
//            an           - anode drive under observation
//            seg          - segment drive gfedcba, 0 = segment on
//            digits       - digits[4i+3:4i] = last captured code of position i
//            digit_valid  - bit i set when position i holds a legal code
//            frame_done   - 1-cycle pulse, every position captured since the
//                           previous pulse
//            err_pattern  - 1-cycle pulse, stable pattern not decodable
//            err_anode    - level, registered anode bus selects >1 position
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_capture #(
  parameter int NUM_DIGITS       = 4,
  parameter int STABLE_CYCLES    = 4,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    err_pattern,
  output logic                    err_anode
);

  localparam int c_cnt_w = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(STABLE_CYCLES - 1);
  // Anode level that selects no position; the sample registers reset to it so
  // that leaving reset never looks like a multi-hot or selected bus.
  localparam logic [NUM_DIGITS-1:0] c_idle_an =
    (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [NUM_DIGITS-1:0] c_all = {NUM_DIGITS{1'b1}};

  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_prev_an;
  logic [6:0]            r_prev_seg;
  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_armed;
  logic [NUM_DIGITS-1:0] r_seen;

  logic [NUM_DIGITS-1:0] w_sel;
  logic                  w_multi;
  logic                  w_onehot;
  logic                  w_restart;
  logic [c_cnt_w-1:0]    w_run;
  logic                  w_armed;
  logic                  w_capture;
  logic [3:0]            w_code;
  logic                  w_legal;
  logic [NUM_DIGITS-1:0] w_seen_next;
  logic                  w_frame;

  // Selection mask with polarity removed: bit i set means position i driven.
  assign w_sel    = (ANODE_ACTIVE_LOW != 0) ? ~r_an : r_an;
  assign w_multi  = (w_sel & (w_sel - NUM_DIGITS'(1))) != '0;
  assign w_onehot = (w_sel != '0) && !w_multi;

  // w_run is the length-minus-one of the run of identical samples ending at
  // the current r_an/r_seg. r_cnt holds the run as of the previous sample, so
  // the run is known in the same cycle the sample lands and the capture edge
  // follows the STABLE_CYCLES-th identical sample directly.
  assign w_restart = (r_an != r_prev_an) || (r_seg != r_prev_seg) || !w_onehot;
  assign w_run     = w_restart ? '0 :
                     ((r_cnt < c_last) ? r_cnt + c_cnt_w'(1) : r_cnt);
  assign w_armed   = w_restart || r_armed;
  assign w_capture = w_armed && w_onehot && (w_run == c_last);

  always_comb begin
    w_code  = 4'hF;
    w_legal = 1'b1;
    case (r_seg)
      7'b1000000: w_code = 4'h0;
      7'b1111001: w_code = 4'h1;
      7'b0100100: w_code = 4'h2;
      7'b0110000: w_code = 4'h3;
      7'b0011001: w_code = 4'h4;
      7'b0010010: w_code = 4'h5;
      7'b0000010: w_code = 4'h6;
      7'b1111000: w_code = 4'h7;
      7'b0000000: w_code = 4'h8;
      7'b0010000: w_code = 4'h9;
      7'b1111111: w_code = 4'hF;
      default:    w_legal = 1'b0;
    endcase
  end

  assign w_seen_next = r_seen | w_sel;
  assign w_frame     = w_capture && w_legal && (w_seen_next == c_all);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an        <= c_idle_an;
      r_seg       <= 7'b1111111;
      r_prev_an   <= c_idle_an;
      r_prev_seg  <= 7'b1111111;
      r_cnt       <= '0;
      r_armed     <= 1'b1;
      r_seen      <= '0;
      digits      <= {NUM_DIGITS{4'hF}};
      digit_valid <= '0;
      frame_done  <= 1'b0;
      err_pattern <= 1'b0;
      err_anode   <= 1'b0;
    end else begin
      r_an       <= an;
      r_seg      <= seg;
      r_prev_an  <= r_an;
      r_prev_seg <= r_seg;
      r_cnt      <= w_run;
      r_armed    <= w_capture ? 1'b0 : w_armed;
      err_anode  <= w_multi;
      frame_done <= w_frame;
      err_pattern <= w_capture && !w_legal;

      if (w_capture) begin
        if (w_legal) begin
          digit_valid <= digit_valid | w_sel;
          r_seen      <= w_frame ? '0 : w_seen_next;
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_sel[i]) begin
              digits[4*i +: 4] <= w_code;
            end
          end
        end else begin
          digit_valid <= digit_valid & ~w_sel;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_capture
// Purpose  : Directed self-checking bench for seven_seg_capture with default
//            parameters (4 digits, 4 stable samples, active-low anodes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_capture;

  logic        clk;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        err_pattern;
  logic        err_anode;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] pat [0:9];

  seven_seg_capture #(
    .NUM_DIGITS      (4),
    .STABLE_CYCLES   (4),
    .ANODE_ACTIVE_LOW(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .an         (an),
    .seg        (seg),
    .digits     (digits),
    .digit_valid(digit_valid),
    .frame_done (frame_done),
    .err_pattern(err_pattern),
    .err_anode  (err_anode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] a;
    pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
    pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
    pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
    pat[9] = 7'b0010000;

    // Reset with random bus contents
    rst_n = 1'b0;
    an    = 4'($urandom);
    seg   = 7'($urandom);
    step();
    step();
    check("rst_digits", digits, 32'hFFFF);
    check("rst_valid", digit_valid, 0);
    check("rst_frame", frame_done, 0);
    check("rst_errp", err_pattern, 0);
    check("rst_erra", err_anode, 0);

    rst_n = 1'b1;
    an    = 4'b1111;
    seg   = 7'b1111111;
    step();
    step();
    check("idle_valid", digit_valid, 0);
    check("idle_erra", err_anode, 0);

    // Single legal hold: capture after the 5th edge, exactly once
    an  = 4'b1110;
    seg = pat[2];
    for (int k = 0; k < 10; k++) begin
      step();
      check("hold_valid", digit_valid, (k >= 4) ? 32'h1 : 32'h0);
      check("hold_digits", digits, (k >= 4) ? 32'hFFF2 : 32'hFFFF);
      check("hold_frame", frame_done, 0);
      check("hold_errp", err_pattern, 0);
    end

    // Pattern changes before the window completes: no capture
    an  = 4'b1101;
    seg = pat[2];
    repeat (3) step();
    seg = pat[3];
    repeat (2) step();
    an  = 4'b1111;
    seg = 7'b1111111;
    repeat (4) step();
    check("short_valid", digit_valid, 32'h1);
    check("short_digits", digits, 32'hFFF2);

    // Two full scans of 1,2,3,4; frame pulse with the position 3 update
    for (int pass = 0; pass < 2; pass++) begin
      for (int p = 0; p < 4; p++) begin
        a   = 4'b0001 << p;
        an  = ~a;
        seg = pat[p+1];
        for (int k = 0; k < 8; k++) begin
          step();
          check("scan_frame", frame_done, (p == 3 && k == 4) ? 32'h1 : 32'h0);
          check("scan_errp", err_pattern, 0);
          if (p == 3 && k == 3)
            check("scan_d3_pre", digits[15:12], (pass == 0) ? 32'hF : 32'h4);
          if (p == 3 && k == 4)
            check("scan_d3", digits[15:12], 32'h4);
        end
      end
      check("scan_digits", digits, 32'h4321);
      check("scan_valid", digit_valid, 32'hF);
    end

    // Illegal pattern on position 1
    an  = 4'b1101;
    seg = 7'b1010101;
    for (int k = 0; k < 8; k++) begin
      step();
      check("bad_errp", err_pattern, (k == 4) ? 32'h1 : 32'h0);
      check("bad_frame", frame_done, 0);
    end
    check("bad_digits", digits, 32'h4321);
    check("bad_valid", digit_valid, 32'hD);

    // Multi-hot anodes
    an  = 4'b1100;
    seg = pat[8];
    for (int k = 0; k < 6; k++) begin
      step();
      check("multi_erra", err_anode, (k >= 1) ? 32'h1 : 32'h0);
      check("multi_frame", frame_done, 0);
      check("multi_errp", err_pattern, 0);
    end
    an = 4'b1111;
    step();
    check("rel_erra0", err_anode, 1);
    step();
    check("rel_erra1", err_anode, 0);
    check("multi_valid", digit_valid, 32'hD);
    check("multi_digits", digits, 32'h4321);

    // Reset in the middle of a legal hold discards the window
    an  = 4'b1110;
    seg = pat[8];
    repeat (3) step();
    rst_n = 1'b0;
    step();
    check("mid_rst_digits", digits, 32'hFFFF);
    check("mid_rst_valid", digit_valid, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_valid", digit_valid, 0);
    end
    an  = 4'b1111;
    seg = 7'b1111111;
    repeat (2) step();
    check("post_rst_idle", digit_valid, 0);

    // A fresh full window after reset captures again
    an  = 4'b1110;
    seg = pat[8];
    for (int k = 0; k < 5; k++) begin
      step();
      check("fresh_valid", digit_valid, (k >= 4) ? 32'h1 : 32'h0);
    end
    check("fresh_digits", digits, 32'hFFF8);
    check("fresh_frame", frame_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
